// File: rtl/ans_pkg.sv
// Shared definitions for the rANS decoder: FSM states and constant helpers.
package ans_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    LOOKUP,
    EMIT,
    UPDATE,
    RENORM
  } ans_state_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'(1) << r) < 64'(n)) r++;
    return r;
  endfunction

  // Lower bound of the normalised state interval, L = 2^(STATE_WIDTH-SYM_WIDTH).
  function automatic longint unsigned l_bound(input int unsigned state_width,
                                              input int unsigned sym_width);
    return 64'(1) << (state_width - sym_width);
  endfunction

endpackage

// File: rtl/ans_icdf_bsearch.sv
// Multicycle binary search over the inclusive cumulative table: finds the
// smallest s with cum[s] > slot, one halving step per enabled cycle.
module ans_icdf_bsearch
  import ans_pkg::*;
#(
  parameter int unsigned SYM_WIDTH = 4,
  parameter int unsigned SYM_COUNT = 16,
  parameter int unsigned CNT_WIDTH = 8,
  parameter int unsigned PROB_BITS = 8
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     en,
  input  logic                                     start,
  input  logic [PROB_BITS-1:0]                     slot,
  input  logic [(CNT_WIDTH+SYM_WIDTH)*SYM_COUNT-1:0] cum_flat,
  output logic [SYM_WIDTH-1:0]                     sym,
  output logic                                     done
);

  localparam int unsigned CW    = CNT_WIDTH + SYM_WIDTH;
  localparam int unsigned STEPS = (clog2(SYM_COUNT) == 0) ? 1 : clog2(SYM_COUNT);
  localparam int unsigned KW    = clog2(STEPS + 1);
  localparam logic [SYM_WIDTH-1:0] LAST = SYM_WIDTH'(SYM_COUNT - 1);
  localparam logic [SYM_WIDTH-1:0] ONE  = SYM_WIDTH'(1);

  logic [SYM_WIDTH-1:0] lo, hi, mid;
  logic [KW-1:0]        left;
  logic [CW-1:0]        cum_mid;

  assign mid     = SYM_WIDTH'(({1'b0, lo} + {1'b0, hi}) >> 1);
  assign cum_mid = cum_flat[mid*CW +: CW];
  assign sym     = lo;
  assign done    = (left == KW'(1));

  // Once converged (lo == hi) further steps leave lo unchanged, so sym holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo   <= '0;
      hi   <= '0;
      left <= '0;
    end else if (en) begin
      if (start) begin
        lo   <= '0;
        hi   <= LAST;
        left <= KW'(STEPS);
      end else if (left != '0) begin
        if (cum_mid > CW'(slot)) hi <= mid;
        else                     lo <= mid + ONE;
        left <= left - KW'(1);
      end
    end
  end

endmodule

// File: rtl/ans_rans_decoder.sv
// Streaming rANS decoder: loads the initial state, then per symbol does an
// ICDF lookup, a state update and digit-wise renormalisation.
module ans_rans_decoder
  import ans_pkg::*;
#(
  parameter int unsigned SYM_WIDTH   = 4,
  parameter int unsigned SYM_COUNT   = 16,
  parameter int unsigned CNT_WIDTH   = 8,
  parameter int unsigned PROB_BITS   = 8,
  parameter int unsigned STATE_WIDTH = 16,
  parameter int unsigned LEN_WIDTH   = 16
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       en,
  input  logic [CNT_WIDTH*SYM_COUNT-1:0]             counts_flat,
  input  logic [(CNT_WIDTH+SYM_WIDTH)*SYM_COUNT-1:0] cum_flat,
  input  logic                                       start,
  input  logic [LEN_WIDTH-1:0]                       frame_len,
  input  logic [SYM_WIDTH-1:0]                       in_data,
  input  logic                                       in_vld,
  output logic                                       in_rdy,
  output logic [SYM_WIDTH-1:0]                       out_data,
  output logic                                       out_vld,
  input  logic                                       out_rdy,
  output logic                                       busy,
  output logic                                       done
);

  localparam int unsigned N_LOAD = STATE_WIDTH / SYM_WIDTH;
  localparam int unsigned DW     = clog2(N_LOAD) + 1;
  localparam int unsigned CW     = CNT_WIDTH + SYM_WIDTH;
  localparam int unsigned PW     = CNT_WIDTH + STATE_WIDTH + 1;
  localparam longint unsigned L_VAL = l_bound(STATE_WIDTH, SYM_WIDTH);

  ans_state_e           state, state_n;
  logic [STATE_WIDTH-1:0] x, x_n, x_sh, x_upd;
  logic [DW-1:0]        dcnt, dcnt_n;
  logic [LEN_WIDTH-1:0] rem, rem_n;
  logic                 done_q, done_n;
  logic                 bs_start, bs_done;
  logic [SYM_WIDTH-1:0] bs_sym;
  logic [PROB_BITS-1:0] slot;
  logic [CNT_WIDTH-1:0] freq_s;
  logic [CW-1:0]        cum_s;
  logic                 upd_ge_l, sh_ge_l;

  assign slot   = x[PROB_BITS-1:0];
  assign freq_s = counts_flat[bs_sym*CNT_WIDTH +: CNT_WIDTH];
  assign cum_s  = cum_flat[bs_sym*CW +: CW];
  assign x_sh   = {x[STATE_WIDTH-SYM_WIDTH-1:0], in_data};
  // M is a power of two, so x/M and x%M are the shift and the slot bits.
  assign x_upd  = STATE_WIDTH'(PW'(freq_s) * PW'(x >> PROB_BITS) + PW'(slot)
                              - PW'(cum_s - CW'(freq_s)));
  assign upd_ge_l = (64'(x_upd) >= L_VAL);
  assign sh_ge_l  = (64'(x_sh) >= L_VAL);
  assign busy     = (state != IDLE);
  assign done     = done_q;

  ans_icdf_bsearch #(
    .SYM_WIDTH (SYM_WIDTH),
    .SYM_COUNT (SYM_COUNT),
    .CNT_WIDTH (CNT_WIDTH),
    .PROB_BITS (PROB_BITS)
  ) u_bsearch (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .start    (bs_start),
    .slot     (slot),
    .cum_flat (cum_flat),
    .sym      (bs_sym),
    .done     (bs_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      x      <= '0;
      dcnt   <= '0;
      rem    <= '0;
      done_q <= 1'b0;
    end else if (en) begin
      state  <= state_n;
      x      <= x_n;
      dcnt   <= dcnt_n;
      rem    <= rem_n;
      done_q <= done_n;
    end
  end

  always_comb begin
    state_n  = state;
    x_n      = x;
    dcnt_n   = dcnt;
    rem_n    = rem;
    done_n   = 1'b0;
    bs_start = 1'b0;
    in_rdy   = 1'b0;
    out_vld  = 1'b0;
    out_data = '0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (frame_len == '0) begin
            done_n = 1'b1;
          end else begin
            rem_n   = frame_len;
            x_n     = '0;
            dcnt_n  = '0;
            state_n = LOAD;
          end
        end
      end
      LOAD: begin
        in_rdy = 1'b1;
        if (in_vld) begin
          x_n    = x_sh;
          dcnt_n = dcnt + DW'(1);
          if (dcnt == DW'(N_LOAD - 1)) begin
            state_n  = LOOKUP;
            bs_start = 1'b1;
          end
        end
      end
      LOOKUP: begin
        if (bs_done) state_n = EMIT;
      end
      EMIT: begin
        out_vld  = 1'b1;
        out_data = bs_sym;
        if (out_rdy) state_n = UPDATE;
      end
      UPDATE: begin
        x_n   = x_upd;
        rem_n = rem - LEN_WIDTH'(1);
        if (rem == LEN_WIDTH'(1)) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end else if (!upd_ge_l) begin
          state_n = RENORM;
        end else begin
          state_n  = LOOKUP;
          bs_start = 1'b1;
        end
      end
      RENORM: begin
        in_rdy = 1'b1;
        if (in_vld) begin
          x_n = x_sh;
          if (sh_ge_l) begin
            state_n  = LOOKUP;
            bs_start = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ans_rans_decoder.sv
// Bench for ans_rans_decoder: directed frames plus a random frame produced by
// a reference rANS encoder, checked against a plain-arithmetic decoder model.
module tb_ans_rans_decoder;

  logic        clk = 1'b0;
  logic        rst_n, en, start, in_vld, in_rdy, out_vld, out_rdy, busy, done;
  logic [31:0] counts_flat;
  logic [47:0] cum_flat;
  logic [15:0] frame_len;
  logic [3:0]  in_data, out_data;

  int unsigned passed = 0, total = 0, done_cnt = 0, stall_left = 0;
  bit          rand_mode = 1'b0, pend = 1'b0, rdy_seen = 1'b0;
  logic [3:0]  pend_data = '0;
  int unsigned fr[4], cm[4];
  int unsigned dig_q[$], exp_q[$], frame_digs[$], mdl_syms[$], enc_syms[$];
  int unsigned mdl_x;

  ans_rans_decoder #(
    .SYM_WIDTH   (4),
    .SYM_COUNT   (4),
    .CNT_WIDTH   (8),
    .PROB_BITS   (4),
    .STATE_WIDTH (16),
    .LEN_WIDTH   (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .counts_flat (counts_flat),
    .cum_flat    (cum_flat),
    .start       (start),
    .frame_len   (frame_len),
    .in_data     (in_data),
    .in_vld      (in_vld),
    .in_rdy      (in_rdy),
    .out_data    (out_data),
    .out_vld     (out_vld),
    .out_rdy     (out_rdy),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, passed %0d of %0d", passed, total);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int unsigned act, input int unsigned req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  task automatic set_tables(input int unsigned f0, input int unsigned f1,
                            input int unsigned f2, input int unsigned f3);
    int unsigned acc;
    fr[0] = f0; fr[1] = f1; fr[2] = f2; fr[3] = f3;
    acc = 0;
    for (int unsigned i = 0; i < 4; i++) begin
      acc = acc + fr[i];
      cm[i] = acc;
      counts_flat[i*8 +: 8] = 8'(fr[i]);
      cum_flat[i*12 +: 12]  = 12'(cm[i]);
    end
  endtask

  // Textbook rANS decode: x/M, x%M, linear ICDF scan, renormalise while x < L.
  task automatic model_decode(input int unsigned n);
    int unsigned x, slot, s;
    int p;
    x = 0; p = 0;
    mdl_syms.delete();
    for (int k = 0; k < 4; k++) begin x = x * 16 + frame_digs[p]; p++; end
    for (int unsigned i = 0; i < n; i++) begin
      slot = x % 16;
      s = 0;
      while (s < 3 && cm[s] <= slot) s++;
      mdl_syms.push_back(s);
      x = (fr[s] * (x / 16) + slot - (cm[s] - fr[s])) % 65536;
      if (i + 1 < n)
        while (x < 4096 && p < frame_digs.size()) begin x = x * 16 + frame_digs[p]; p++; end
    end
    mdl_x = x;
  endtask

  // Reference encoder; digits renormalised out before the first-encoded
  // (last-decoded) symbol are never read back and are dropped.
  task automatic rans_encode();
    int unsigned x, f, s;
    int unsigned em[$];
    int n;
    x = 4096;
    n = enc_syms.size();
    for (int i = n - 1; i >= 0; i--) begin
      s = enc_syms[i];
      f = fr[s];
      while (x >= 4096 * f) begin
        if (i != n - 1) em.push_back(x & 15);
        x = x >> 4;
      end
      x = (x / f) * 16 + (x % f) + (cm[s] - f);
    end
    frame_digs.delete();
    for (int k = 3; k >= 0; k--) frame_digs.push_back((x >> (4 * k)) & 15);
    for (int k = em.size() - 1; k >= 0; k--) frame_digs.push_back(em[k]);
  endtask

  task automatic prep(input int unsigned n);
    model_decode(n);
    exp_q = mdl_syms;
    dig_q = frame_digs;
  endtask

  // One cycle: sample settled outputs at negedge, check, drive the next inputs.
  task automatic tick();
    @(negedge clk);
    if (!rst_n) begin pend = 1'b0; return; end
    if (done) done_cnt++;
    if (in_rdy) rdy_seen = 1'b1;
    if (pend) begin
      check("hold_vld", 32'(out_vld), 1);
      check("hold_data", 32'(out_data), 32'(pend_data));
      check("hold_no_in_rdy", 32'(in_rdy), 0);
    end
    in_vld = (dig_q.size() != 0) && (!rand_mode || $urandom_range(0, 3) != 0);
    if (dig_q.size() != 0) in_data = 4'(dig_q[0]);
    else in_data = '0;
    if (out_vld && stall_left != 0) begin
      out_rdy = 1'b0;
      stall_left--;
    end else begin
      out_rdy = !rand_mode || ($urandom_range(0, 2) != 0);
    end
    if (in_vld && in_rdy && en) void'(dig_q.pop_front());
    if (out_vld && out_rdy && en) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL sym_unexpected: got %0d, required no symbol", out_data);
      end else begin
        check("symbol", 32'(out_data), exp_q.pop_front());
      end
    end
    pend      = out_vld && !(out_rdy && en);
    pend_data = out_data;
  endtask

  task automatic run_frame(input int unsigned len, input bit dup,
                           input int unsigned limit, output int lat);
    int unsigned t, base;
    base = done_cnt;
    lat = -1;
    start = 1'b1; frame_len = 16'(len);
    tick();
    if (dup) begin frame_len = 16'd5; tick(); end
    start = 1'b0;
    t = 0;
    while (busy && t < limit) begin
      if (out_vld && lat < 0) lat = int'(t);
      tick();
      t++;
    end
    check("frame_ends", 32'(busy), 0);
    tick(); tick();
    check("done_once", done_cnt - base, 1);
    check("symbols_drained", exp_q.size(), 0);
    check("digits_consumed", dig_q.size(), 0);
  endtask

  initial begin
    int lat;
    int unsigned t, base, mm;
    rst_n = 1'b0; en = 1'b1; start = 1'b0; frame_len = '0;
    in_vld = 1'b0; in_data = '0; out_rdy = 1'b0;
    counts_flat = '0; cum_flat = '0;
    set_tables(8, 4, 2, 2);
    tick(); tick();
    check("rst_in_rdy", 32'(in_rdy), 0);
    check("rst_out_vld", 32'(out_vld), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    rst_n = 1'b1;
    tick(); tick();
    check("idle_busy", 32'(busy), 0);

    // Basic frame: 0x1234 -> sym 0, x=2332, digit A -> 37322 -> sym 1, x=9330.
    frame_digs = '{1, 2, 3, 4, 10};
    prep(2);
    check("model_nsym", mdl_syms.size(), 2);
    check("model_sym0", mdl_syms[0], 0);
    check("model_sym1", mdl_syms[1], 1);
    check("model_final_x", mdl_x, 9330);
    run_frame(2, 1'b0, 200, lat);
    check("first_out_latency", 32'(lat), 6);

    // Output backpressure on the first symbol.
    prep(2);
    stall_left = 5;
    run_frame(2, 1'b0, 200, lat);

    // Slot boundaries at cumulative edges.
    frame_digs = '{1, 0, 0, 7}; prep(1);
    check("model_slot7", mdl_syms[0], 0);
    run_frame(1, 1'b0, 200, lat);
    check("slot7_latency", 32'(lat), 6);
    frame_digs = '{1, 0, 0, 8}; prep(1);
    check("model_slot8", mdl_syms[0], 1);
    run_frame(1, 1'b0, 200, lat);
    frame_digs = '{1, 0, 0, 15}; prep(1);
    check("model_slot15", mdl_syms[0], 3);
    run_frame(1, 1'b0, 200, lat);

    // Zero-frequency symbol is skipped.
    set_tables(8, 0, 4, 4);
    frame_digs = '{1, 0, 0, 8}; prep(1);
    check("model_zero_freq", mdl_syms[0], 2);
    run_frame(1, 1'b0, 200, lat);
    set_tables(8, 4, 2, 2);

    // Empty frame: done without consuming input.
    dig_q = '{5};
    base = done_cnt; rdy_seen = 1'b0;
    start = 1'b1; frame_len = '0;
    tick();
    start = 1'b0;
    tick(); tick();
    check("len0_done_once", done_cnt - base, 1);
    check("len0_no_in_rdy", 32'(rdy_seen), 0);
    check("len0_digit_kept", dig_q.size(), 1);
    check("len0_busy", 32'(busy), 0);
    dig_q.delete();

    // Reset while waiting for a renormalisation digit.
    frame_digs = '{1, 2, 3, 4}; prep(1);
    base = done_cnt;
    start = 1'b1; frame_len = 16'd2;
    tick();
    start = 1'b0;
    t = 0;
    while (!(in_rdy && busy && exp_q.size() == 0) && t < 100) begin tick(); t++; end
    check("reached_renorm", 32'(in_rdy && busy && exp_q.size() == 0), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_rdy", 32'(in_rdy), 0);
    check("mid_rst_out_vld", 32'(out_vld), 0);
    check("mid_rst_out_data", 32'(out_data), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_done", 32'(done), 0);
    tick(); tick();
    rst_n = 1'b1;
    exp_q.delete(); dig_q.delete();
    repeat (6) tick();
    check("post_rst_busy", 32'(busy), 0);
    check("post_rst_out_vld", 32'(out_vld), 0);
    check("post_rst_no_done", done_cnt - base, 0);

    // Second start while busy must be ignored.
    frame_digs = '{1, 2, 3, 4}; prep(1);
    run_frame(1, 1'b1, 200, lat);

    // Random symbols through the reference encoder, random stalls.
    enc_syms.delete();
    for (int i = 0; i < 1000; i++) enc_syms.push_back($urandom_range(0, 3));
    rans_encode();
    model_decode(1000);
    mm = 0;
    for (int i = 0; i < 1000; i++) if (mdl_syms[i] != enc_syms[i]) mm++;
    check("model_vs_encoder", mm, 0);
    exp_q = enc_syms;
    dig_q = frame_digs;
    rand_mode = 1'b1;
    run_frame(1000, 1'b0, 40000, lat);
    rand_mode = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ans_rans_decoder.md
Name: ans_rans_decoder

Overview:
- Parametrised streaming rANS decoder; successor to the single-configuration ans_decoder.
- Loads an initial state from the bitstream, then emits up to frame_len symbols. Per symbol: ICDF lookup (binary search), state update, renormalisation from input digits.
- Probability total is fixed at 2^PROB_BITS, so division and modulo reduce to shift and mask.
- Sits between the digit-stream unpacker (upstream) and the symbol sink (downstream) in the codec datapath.

Parameters:
- SYM_WIDTH, 4, bits per input digit and per output symbol
- SYM_COUNT, 16, alphabet size; must be ≤ 2^SYM_WIDTH
- CNT_WIDTH, 8, width of each per-symbol frequency
- PROB_BITS, 8, log2 of the frequency total; must be ≤ STATE_WIDTH-SYM_WIDTH and < CNT_WIDTH+SYM_WIDTH
- STATE_WIDTH, 16, state register width; must be a multiple of SYM_WIDTH
- LEN_WIDTH, 16, width of frame_len

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  clock enable; when low, all registers hold
- counts_flat  in  CNT_WIDTH*SYM_COUNT  freq[i] at slice i
- cum_flat  in  (CNT_WIDTH+SYM_WIDTH)*SYM_COUNT  inclusive cumulative cum[i] = freq[0..i]; cum[SYM_COUNT-1] must equal 2^PROB_BITS
- start  in  1  pulse: begin a frame; ignored unless idle
- frame_len  in  LEN_WIDTH  symbols to decode; latched on start
- in_data  in  SYM_WIDTH  input digit
- in_vld  in  1  input valid
- in_rdy  out  1  input ready
- out_data  out  SYM_WIDTH  decoded symbol
- out_vld  out  1  output valid
- out_rdy  in  1  output ready
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse when the frame completes

Behaviour:
- Reset values: in_rdy=0, out_vld=0, out_data=0, busy=0, done=0; state register, digit counter, symbol counter and FSM all cleared (FSM=IDLE). Reset mid-frame abandons the frame with no residual output.
- Handshake: a transfer occurs on a cycle with vld&rdy&en.
  - in_rdy is high only in LOAD and RENORM.
  - out_vld, once raised, holds with out_data stable until accepted.
- Constants: L = 2^(STATE_WIDTH-SYM_WIDTH); M = 2^PROB_BITS.
- FSM:
  - IDLE: busy=0. On start with frame_len=0: done pulses next cycle, stay IDLE. On start otherwise: latch frame_len, clear x, go LOAD.
  - LOAD: accept STATE_WIDTH/SYM_WIDTH digits, MSB first; x = (x << SYM_WIDTH) | in_data. After the last digit, go LOOKUP.
  - LOOKUP: slot = x & (M-1). Binary search for the smallest s with cum[s] > slot, taking exactly ceil(log2 SYM_COUNT) cycles (minimum 1). Go EMIT.
  - EMIT: out_vld=1, out_data=s. On acceptance, go UPDATE.
  - UPDATE (1 cycle): x = freq[s]*(x >> PROB_BITS) + slot − (cum[s] − freq[s]). Computed at full precision, result truncated to STATE_WIDTH. Decrement the remaining count.
    - If remaining=0: done pulse, go IDLE. The final state is not renormalised.
    - Else if x < L: go RENORM.
    - Else: go LOOKUP.
  - RENORM: per accepted digit, x = (x << SYM_WIDTH) | in_data, then re-test against L; return to LOOKUP when x ≥ L. Multiple digits are allowed in succession.
- Zero-frequency symbols are never selected, since cum[s] > slot is strict.
- A symbol is never issued before the previous one has been accepted: at most one output is outstanding.
- start while busy is ignored. in_vld outside LOAD/RENORM is not consumed.
- Latency with in_vld=out_rdy=1 continuously: first out_vld appears N_load + ceil(log2 SYM_COUNT) cycles after start; each subsequent symbol takes lookup + 1 emit + 1 update + renorm digits.
- The tables must be stable while busy=1; changing them mid-frame gives undefined output.

Decomposition:
- Shared package ans_pkg: FSM state enum (IDLE, LOAD, LOOKUP, EMIT, UPDATE, RENORM) and helper functions clog2 and l_bound.
- Sub-module ans_icdf_bsearch: parametrised multicycle binary-search ICDF. Interface: start, slot, cum_flat, sym, done; latency exactly ceil(log2 SYM_COUNT).

Test Plan:
- Test configuration for all scenarios: SYM_WIDTH=4, SYM_COUNT=4, PROB_BITS=4, STATE_WIDTH=16, freq={8,4,2,2}, cum={8,12,14,16}.
- Frame: frame_len=2; digits 1,2,3,4,A.
  - Expected: after 4 load digits x=0x1234; symbol 0 is emitted; x becomes 2332 (<4096), so one digit A is taken and x=37322; symbol 1 is emitted; x becomes 9330; done pulses.
- Backpressure: same frame with out_rdy low for 5 cycles → out_vld and out_data hold; no digit is consumed and in_rdy=0 while stalled.
- Slot boundaries: x=0x1007 gives symbol 0; x=0x1008 gives symbol 1; x=0x100F gives symbol 3 (freq checks at cum edges).
- Zero frequency: freq={8,0,4,4}, cum={8,8,12,16}, slot=8 → symbol 2, never 1.
- Control: frame_len=0 → done pulses once with no in_rdy; assert rst_n low during RENORM → all outputs return to reset values; start during busy is ignored.
- Random: 1000 symbols from a reference rANS encoder model with random in_vld/out_rdy stalls → symbol stream matches the model.
